// File: rtl/axi_ram_slave.sv
// AXI4 burst RAM slave: independent read and write FSMs sharing one byte-laned block RAM.
// Define AXI_RAM_RANGE_CHECK_EN to reject out-of-range beats with SLVERR; otherwise addresses wrap.
module axi_ram_slave #(
    parameter int MEM_WORDS = 4096
) (
    input  logic        CLK,
    input  logic        RST,

    input  logic        S_AXI_AWID,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [7:0]  S_AXI_AWLEN,
    input  logic [2:0]  S_AXI_AWSIZE,
    input  logic [1:0]  S_AXI_AWBURST,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,

    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WLAST,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,

    output logic        S_AXI_BID,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,

    input  logic        S_AXI_ARID,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [7:0]  S_AXI_ARLEN,
    input  logic [2:0]  S_AXI_ARSIZE,
    input  logic [1:0]  S_AXI_ARBURST,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,

    output logic        S_AXI_RID,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RLAST,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY
);
    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] { W_IDLE, W_DATA, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst);
        return (burst == 2'b00) ? addr : addr + 32'd4;
    endfunction

    // Write-path state
    w_state_t    w_state_q, w_state_d;
    logic        awready_q, wready_q, bvalid_q;
    logic        bid_q, bid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [31:0] w_addr_q, w_addr_d;
    logic [7:0]  w_len_q, w_len_d;
    logic [7:0]  w_beat_q, w_beat_d;
    logic [1:0]  w_burst_q, w_burst_d;
    logic        w_err_q, w_err_d;

    // Read-path state
    r_state_t    r_state_q, r_state_d;
    logic        arready_q, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic        rid_q, rid_d;
    logic [31:0] r_addr_q, r_addr_d;
    logic [7:0]  r_len_q, r_len_d;
    logic [7:0]  r_beat_q, r_beat_d;
    logic [1:0]  r_burst_q, r_burst_d;
    logic        rd_oor_q;

    // Memory ports
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic          mem_re;
    logic [31:0]   rd_addr;
    logic [AW-1:0] mem_raddr;
    logic [31:0]   mem_rdata;

    logic w_beat_oor;
    logic rd_oor;

    assign mem_waddr = w_addr_q[AW+1:2];
    assign mem_wdata = S_AXI_WDATA;
    assign mem_raddr = rd_addr[AW+1:2];

    // One RAM per byte lane so strobes map onto plain per-lane write enables; read-first on collision.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [MEM_WORDS];
            logic [7:0] lane_rd_q;
            always_ff @(posedge CLK) begin
                if (mem_we[gi]) begin
                    lane_mem[mem_waddr] <= mem_wdata[8*gi +: 8];
                end
                if (mem_re) begin
                    lane_rd_q <= lane_mem[mem_raddr];
                end
            end
            assign mem_rdata[8*gi +: 8] = lane_rd_q;
        end
    endgenerate

`ifdef AXI_RAM_RANGE_CHECK_EN
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;
    assign w_beat_oor = ({1'b0, w_addr_q} >= MEM_BYTES);
    assign rd_oor     = ({1'b0, rd_addr} >= MEM_BYTES);
`else
    assign w_beat_oor = 1'b0;
    assign rd_oor     = 1'b0;
    logic unused_rd_addr;
    assign unused_rd_addr = ^{rd_addr[31:AW+2], rd_addr[1:0]};
`endif

    // Beats are always 32 bits and burst length alone ends a write.
    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWSIZE, S_AXI_ARSIZE, S_AXI_WLAST};

    always_comb begin
        w_state_d = w_state_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_beat_d  = w_beat_q;
        w_burst_d = w_burst_q;
        w_err_d   = w_err_q;
        mem_we    = 4'b0000;
        case (w_state_q)
            W_IDLE: begin
                if (S_AXI_AWVALID && awready_q) begin
                    w_state_d = W_DATA;
                    bid_d     = S_AXI_AWID;
                    w_addr_d  = S_AXI_AWADDR;
                    w_len_d   = S_AXI_AWLEN;
                    w_burst_d = S_AXI_AWBURST;
                    w_beat_d  = 8'd0;
                    w_err_d   = 1'b0;
                end
            end
            W_DATA: begin
                if (S_AXI_WVALID && wready_q) begin
                    mem_we = (w_beat_oor || RST) ? 4'b0000 : S_AXI_WSTRB;
                    if (w_beat_q == w_len_q) begin
                        w_state_d = W_RESP;
                        bresp_d   = (w_err_q || w_beat_oor) ? 2'b10 : 2'b00;
                    end else begin
                        w_beat_d = w_beat_q + 8'd1;
                        w_addr_d = next_addr(w_addr_q, w_burst_q);
                        w_err_d  = w_err_q || w_beat_oor;
                    end
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY && bvalid_q) begin
                    w_state_d = W_IDLE;
                    bresp_d   = 2'b00;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the next state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= 1'b0;
            bresp_q   <= 2'b00;
            w_addr_q  <= 32'd0;
            w_len_q   <= 8'd0;
            w_beat_q  <= 8'd0;
            w_burst_q <= 2'b00;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= (w_state_d == W_IDLE);
            wready_q  <= (w_state_d == W_DATA);
            bvalid_q  <= (w_state_d == W_RESP);
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_beat_q  <= w_beat_d;
            w_burst_q <= w_burst_d;
            w_err_q   <= w_err_d;
        end
    end

    // The RAM read register only loads on a new beat, so stalled data stays put.
    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_beat_d  = r_beat_q;
        r_burst_d = r_burst_q;
        rid_d     = rid_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        mem_re    = 1'b0;
        rd_addr   = r_addr_q;
        case (r_state_q)
            R_IDLE: begin
                if (S_AXI_ARVALID && arready_q) begin
                    r_state_d = R_DATA;
                    r_addr_d  = S_AXI_ARADDR;
                    r_len_d   = S_AXI_ARLEN;
                    r_burst_d = S_AXI_ARBURST;
                    r_beat_d  = 8'd0;
                    rid_d     = S_AXI_ARID;
                    rvalid_d  = 1'b1;
                    rlast_d   = (S_AXI_ARLEN == 8'd0);
                    mem_re    = 1'b1;
                    rd_addr   = S_AXI_ARADDR;
                end
            end
            R_DATA: begin
                if (rvalid_q && S_AXI_RREADY) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                    end else begin
                        rd_addr  = next_addr(r_addr_q, r_burst_q);
                        r_addr_d = rd_addr;
                        r_beat_d = r_beat_q + 8'd1;
                        rlast_d  = ((r_beat_q + 8'd1) == r_len_q);
                        mem_re   = 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= 1'b0;
            r_addr_q  <= 32'd0;
            r_len_q   <= 8'd0;
            r_beat_q  <= 8'd0;
            r_burst_q <= 2'b00;
            rd_oor_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= (r_state_d == R_IDLE);
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_beat_q  <= r_beat_d;
            r_burst_q <= r_burst_d;
            if (mem_re) begin
                rd_oor_q <= rd_oor;
            end
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BID     = bid_q;
    assign S_AXI_BRESP   = bresp_q;

    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RID     = rid_q;
    assign S_AXI_RDATA   = (rvalid_q && !rd_oor_q) ? mem_rdata : 32'd0;
    assign S_AXI_RRESP   = (rvalid_q && rd_oor_q) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: a word model plus an expected-beat queue checks every R beat and B response.
module tb_axi_ram_slave;
    localparam int MEM_WORDS = 4096;
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;
`ifdef AXI_RAM_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    logic        CLK, RST;
    logic        S_AXI_AWID;
    logic [31:0] S_AXI_AWADDR;
    logic [7:0]  S_AXI_AWLEN;
    logic [2:0]  S_AXI_AWSIZE;
    logic [1:0]  S_AXI_AWBURST;
    logic        S_AXI_AWVALID, S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
    logic        S_AXI_BID;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID, S_AXI_BREADY;
    logic        S_AXI_ARID;
    logic [31:0] S_AXI_ARADDR;
    logic [7:0]  S_AXI_ARLEN;
    logic [2:0]  S_AXI_ARSIZE;
    logic [1:0]  S_AXI_ARBURST;
    logic        S_AXI_ARVALID, S_AXI_ARREADY;
    logic        S_AXI_RID;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] model_mem [MEM_WORDS];
    logic [31:0] exp_data_q [$];
    logic [1:0]  exp_resp_q [$];
    logic [31:0] last_rdata;

    axi_ram_slave #(.MEM_WORDS(MEM_WORDS)) dut (
        .CLK(CLK), .RST(RST),
        .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit oor(input logic [31:0] a);
        return RANGE_CHECK && (a >= 32'(MEM_WORDS * 4));
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] burst);
        return (burst == FIXED) ? a : a + 32'd4;
    endfunction

    function automatic void model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [AW-1:0] idx;
        if (oor(a)) return;
        idx = a[AW+1:2];
        for (int b = 0; b < 4; b++) begin
            if (s[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
        end
    endfunction

    function automatic logic [31:0] model_rd_data(input logic [31:0] a);
        logic [AW-1:0] idx;
        idx = a[AW+1:2];
        return oor(a) ? 32'd0 : model_mem[idx];
    endfunction

    function automatic logic [1:0] model_rd_resp(input logic [31:0] a);
        return oor(a) ? 2'b10 : 2'b00;
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [31:0] base, input logic [31:0] inc, input logic [3:0] strb,
                             input int bdelay, input bit early_last, input logic id, input string tag);
        logic [31:0] a;
        logic [1:0]  exp_resp;
        int t;
        a = addr;
        exp_resp = 2'b00;
        S_AXI_BREADY  = (bdelay == 0);
        S_AXI_AWID    = id;
        S_AXI_AWADDR  = addr;
        S_AXI_AWLEN   = len;
        S_AXI_AWBURST = burst;
        S_AXI_AWVALID = 1'b1;
        t = 0;
        while (!S_AXI_AWREADY && t < 50) begin step(); t++; end
        check({tag, "_awready"}, S_AXI_AWREADY, 1);
        step();
        S_AXI_AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            S_AXI_WDATA  = base + inc * 32'(i);
            S_AXI_WSTRB  = strb;
            S_AXI_WLAST  = early_last ? (i == 0) : (i == int'(len));
            S_AXI_WVALID = 1'b1;
            t = 0;
            while (!S_AXI_WREADY && t < 50) begin step(); t++; end
            check({tag, "_wready"}, S_AXI_WREADY, 1);
            step();
            model_wr(a, S_AXI_WDATA, strb);
            if (oor(a)) exp_resp = 2'b10;
            a = next_addr(a, burst);
            if (i < int'(len)) check({tag, "_bearly"}, S_AXI_BVALID, 0);
        end
        S_AXI_WVALID = 1'b0;
        S_AXI_WLAST  = 1'b0;
        for (int k = 0; k < bdelay; k++) begin
            check({tag, "_bhold"}, S_AXI_BVALID, 1);
            step();
        end
        S_AXI_BREADY = 1'b1;
        check({tag, "_bvalid"}, S_AXI_BVALID, 1);
        check({tag, "_bid"}, S_AXI_BID, id);
        check({tag, "_bresp"}, S_AXI_BRESP, exp_resp);
        step();
        S_AXI_BREADY = 1'b0;
        check({tag, "_bdone"}, S_AXI_BVALID, 0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic id, input bit toggle, input string tag);
        logic [31:0] a, held, exp_d;
        logic [1:0]  exp_r;
        bit stalled;
        int beats, t;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            exp_data_q.push_back(model_rd_data(a));
            exp_resp_q.push_back(model_rd_resp(a));
            a = next_addr(a, burst);
        end
        S_AXI_ARID    = id;
        S_AXI_ARADDR  = addr;
        S_AXI_ARLEN   = len;
        S_AXI_ARBURST = burst;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b0;
        t = 0;
        while (!S_AXI_ARREADY && t < 50) begin step(); t++; end
        check({tag, "_arready"}, S_AXI_ARREADY, 1);
        step();
        S_AXI_ARVALID = 1'b0;
        check({tag, "_rlatency"}, S_AXI_RVALID, 1);
        beats = 0;
        t = 0;
        stalled = 1'b0;
        held = 32'd0;
        while (beats <= int'(len) && t < 1200) begin
            S_AXI_RREADY = toggle ? (t % 2 == 1) : 1'b1;
            if (!toggle) check({tag, "_nobubble"}, S_AXI_RVALID, 1);
            if (S_AXI_RVALID) begin
                if (stalled) check({tag, "_hold"}, S_AXI_RDATA, held);
                if (S_AXI_RREADY) begin
                    exp_d = exp_data_q.pop_front();
                    exp_r = exp_resp_q.pop_front();
                    check({tag, "_rdata"}, S_AXI_RDATA, exp_d);
                    check({tag, "_rresp"}, S_AXI_RRESP, exp_r);
                    check({tag, "_rlast"}, S_AXI_RLAST, (beats == int'(len)));
                    check({tag, "_rid"}, S_AXI_RID, id);
                    last_rdata = S_AXI_RDATA;
                    beats++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = S_AXI_RDATA;
                end
            end
            step();
            t++;
        end
        S_AXI_RREADY = 1'b0;
        exp_data_q.delete();
        exp_resp_q.delete();
        check({tag, "_beats"}, 32'(beats), 32'(len) + 32'd1);
        check({tag, "_idle"}, S_AXI_RVALID, 0);
    endtask

    initial begin
        int t;
        RST = 1'b1;
        S_AXI_AWID = 1'b0; S_AXI_AWADDR = 32'd0; S_AXI_AWLEN = 8'd0; S_AXI_AWSIZE = 3'd2;
        S_AXI_AWBURST = INCR; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = 32'd0; S_AXI_WSTRB = 4'h0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARID = 1'b0; S_AXI_ARADDR = 32'd0; S_AXI_ARLEN = 8'd0; S_AXI_ARSIZE = 3'd2;
        S_AXI_ARBURST = INCR; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
        last_rdata = 32'd0;
        repeat (3) step();

        check("rst_awready", S_AXI_AWREADY, 0);
        check("rst_arready", S_AXI_ARREADY, 0);
        check("rst_wready", S_AXI_WREADY, 0);
        check("rst_bvalid", S_AXI_BVALID, 0);
        check("rst_rvalid", S_AXI_RVALID, 0);
        check("rst_rlast", S_AXI_RLAST, 0);
        check("rst_rdata", S_AXI_RDATA, 0);
        check("rst_resp", {S_AXI_RRESP, S_AXI_BRESP}, 0);
        check("rst_ids", {S_AXI_RID, S_AXI_BID}, 0);
        RST = 1'b0;
        step();
        check("rel_awready", S_AXI_AWREADY, 1);
        check("rel_arready", S_AXI_ARREADY, 1);

        axi_write(32'h10, 8'd0, INCR, 32'hDEADBEEF, 32'd0, 4'hF, 0, 1'b0, 1'b1, "single_wr");
        axi_read(32'h10, 8'd0, INCR, 1'b0, 1'b0, "single_rd");
        check("single_const", last_rdata, 32'hDEADBEEF);

        axi_write(32'h20, 8'd0, INCR, 32'hFFFFFFFF, 32'd0, 4'hF, 0, 1'b0, 1'b0, "strb_fill");
        axi_write(32'h20, 8'd0, INCR, 32'h11223344, 32'd0, 4'b0101, 0, 1'b0, 1'b1, "strb_wr");
        axi_read(32'h20, 8'd0, INCR, 1'b1, 1'b0, "strb_rd");
        check("strb_const", last_rdata, 32'hFF22FF44);

        axi_write(32'h100, 8'd7, INCR, 32'hA0000000, 32'h01010101, 4'hF, 5, 1'b0, 1'b1, "incr_wr");
        axi_read(32'h100, 8'd7, INCR, 1'b1, 1'b0, "incr_rd");
        axi_read(32'h100, 8'd3, INCR, 1'b0, 1'b1, "bp_rd");

        axi_write(32'h200, 8'd3, FIXED, 32'hB0000000, 32'd1, 4'hF, 0, 1'b0, 1'b0, "fixed_wr");
        axi_read(32'h200, 8'd2, FIXED, 1'b0, 1'b0, "fixed_rd");
        check("fixed_const", last_rdata, 32'hB0000003);

        axi_write(32'h300, 8'd1, WRAP, 32'hC0000000, 32'd1, 4'hF, 2, 1'b1, 1'b1, "early_wr");
        axi_read(32'h300, 8'd1, WRAP, 1'b1, 1'b0, "early_rd");

        axi_write(32'h800, 8'd255, INCR, 32'h50000000, 32'd1, 4'hF, 0, 1'b0, 1'b0, "len255_wr");
        axi_read(32'h800, 8'd255, INCR, 1'b1, 1'b0, "len255_rd");

        // Reset arrives while beat 2 of an 8-beat read is being presented.
        S_AXI_ARID = 1'b1; S_AXI_ARADDR = 32'h100; S_AXI_ARLEN = 8'd7; S_AXI_ARBURST = INCR;
        S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        t = 0;
        while (!S_AXI_ARREADY && t < 50) begin step(); t++; end
        check("rmb_arready", S_AXI_ARREADY, 1);
        step();
        S_AXI_ARVALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("rmb_rvalid", S_AXI_RVALID, 1);
            check("rmb_rdata", S_AXI_RDATA, model_rd_data(32'h100 + 32'(4 * i)));
            step();
        end
        RST = 1'b1;
        step();
        check("rmb_rst_rvalid", S_AXI_RVALID, 0);
        check("rmb_rst_arready", S_AXI_ARREADY, 0);
        check("rmb_rst_rdata", S_AXI_RDATA, 0);
        check("rmb_rst_rid", S_AXI_RID, 0);
        step();
        check("rmb_rst_rvalid2", S_AXI_RVALID, 0);
        RST = 1'b0;
        step();
        check("rmb_rel_arready", S_AXI_ARREADY, 1);
        for (int i = 0; i < 4; i++) begin
            check("rmb_no_stale", S_AXI_RVALID, 0);
            step();
        end
        S_AXI_RREADY = 1'b0;

        axi_write(32'h0, 8'd0, INCR, 32'h12345678, 32'd0, 4'hF, 0, 1'b0, 1'b0, "base_wr");
        axi_write(32'h4000, 8'd0, INCR, 32'hCAFEF00D, 32'd0, 4'hF, 0, 1'b0, 1'b1, "oor_wr");
        axi_read(32'h0, 8'd0, INCR, 1'b0, 1'b0, "oor_base_rd");
        check("oor_base_const", last_rdata, RANGE_CHECK ? 32'h12345678 : 32'hCAFEF00D);
        axi_read(32'h4000, 8'd0, INCR, 1'b1, 1'b0, "oor_rd");
        check("oor_rd_const", last_rdata, RANGE_CHECK ? 32'h00000000 : 32'hCAFEF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axi_ram_slave.md
AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096, meaning memory depth in 32-bit words (power of 2).
REQ-002 SHALL have ports:
- CLK  in  1  sole clock for all logic.
- RST  in  1  synchronous, active-high reset.
REQ-003 SHALL have AW channel ports:
- S_AXI_AWID in 1; AWADDR in 32; AWLEN in 8; AWSIZE in 3; AWBURST in 2; AWVALID in 1.
- S_AXI_AWREADY out 1.
REQ-004 SHALL have W channel ports:
- S_AXI_WDATA in 32; WSTRB in 4; WLAST in 1; WVALID in 1.
- S_AXI_WREADY out 1.
REQ-005 SHALL have B channel ports:
- S_AXI_BID out 1; BRESP out 2; BVALID out 1.
- S_AXI_BREADY in 1.
REQ-006 SHALL have AR channel ports:
- S_AXI_ARID in 1; ARADDR in 32; ARLEN in 8; ARSIZE in 3; ARBURST in 2; ARVALID in 1.
- S_AXI_ARREADY out 1.
REQ-007 SHALL have R channel ports:
- S_AXI_RID out 1; RDATA out 32; RRESP out 2; RLAST out 1; RVALID out 1.
- S_AXI_RREADY in 1.

Function
REQ-008 SHALL run read and write paths as independent FSMs sharing one memory array (1 write port, 1 read port); simultaneous read/write of the same word SHALL return the old data.
REQ-009 SHALL compute word index as addr[log2(MEM_WORDS)+1:2]; AxSIZE SHALL be ignored (32-bit beats only).
REQ-010 SHALL advance the address +4 per beat for INCR (01) and WRAP (10), and hold it constant for FIXED (00).
REQ-011 SHALL implement read FSM states R_IDLE, R_DATA:
- R_IDLE: ARREADY=1; on ARVALID&ARREADY latch ARID/ARADDR/ARLEN/ARBURST, beat counter=0, go R_DATA.
- R_DATA: ARREADY=0.
REQ-012 SHALL assert RVALID the cycle after the AR handshake, with RDATA = mem[ARADDR] (1-cycle latency); RID = latched ARID.
REQ-013 SHALL hold RDATA/RLAST/RVALID stable while RVALID & !RREADY.
REQ-014 SHALL, on each RVALID&RREADY, advance to the next beat, presenting the next word on the following cycle (back-to-back beats, no bubble).
REQ-015 SHALL assert RLAST only on beat ARLEN; the handshake of the last beat SHALL return the FSM to R_IDLE with RVALID=0 next cycle.
REQ-016 SHALL implement write FSM states W_IDLE, W_DATA, W_RESP:
- W_IDLE: AWREADY=1; on handshake latch AWID/AWADDR/AWLEN/AWBURST, go W_DATA.
- W_DATA: WREADY=1.
- W_RESP: BVALID=1.
REQ-017 SHALL, in W_DATA on each WVALID&WREADY, write byte lane i of WDATA only where WSTRB[i]=1.
REQ-018 SHALL end the write burst when the beat counter equals AWLEN, regardless of WLAST; an early WLAST SHALL be ignored.
REQ-019 SHALL hold BVALID, BID = latched AWID, BRESP until BREADY; the handshake SHALL return the FSM to W_IDLE.
REQ-020 SHALL drive RRESP/BRESP = 2'b00 (OKAY) unless REQ-026 applies.
REQ-021 SHALL accept AWLEN/ARLEN = 0 (single beat) and 255 (256 beats); beat counters SHALL be 8-bit.

Reset
REQ-022 SHALL, while RST=1, drive all READY/VALID outputs, RLAST, RDATA, RRESP, BRESP, RID and BID to 0 and force both FSMs to IDLE.
REQ-023 SHALL register AWREADY/ARREADY so they rise the first cycle after RST deasserts.
REQ-024 SHALL abandon any in-flight burst on reset mid-operation, issuing no further R beats or B response.
REQ-025 SHALL NOT reset memory contents.

Configuration
REQ-026 SHALL compile a range check in when AXI_RAM_RANGE_CHECK_EN is defined:
- Per beat, byte address >= MEM_WORDS*4 → write suppressed; read returns RDATA=0, RRESP=2'b10.
- Burst BRESP=2'b10 if any beat was out of range.
REQ-027 SHALL, without AXI_RAM_RANGE_CHECK_EN, wrap addresses modulo MEM_WORDS*4 and always return OKAY.

Verification
REQ-028 SHALL test single write: AW 0x10 LEN 0, W 0xDEADBEEF STRB 0xF, BREADY=1 → BVALID 1 cycle after the W beat, BRESP 0; then AR 0x10 → RDATA 0xDEADBEEF, RLAST=1.
REQ-029 SHALL test strobes: write 0x11223344 STRB 0b0101 over 0xFFFFFFFF → readback 0xFF22FF44.
REQ-030 SHALL test INCR read: AR 0x100 LEN 7, RREADY held 1 → 8 consecutive beats 0x100..0x11C, RLAST on 8th only.
REQ-031 SHALL test backpressure: RREADY toggled every other cycle during a LEN 3 burst → RDATA stable while stalled, 4 beats, no data loss; BREADY delayed 5 cycles → BVALID held.
REQ-032 SHALL test reset mid-burst: RST pulsed after beat 2 of a LEN 7 read → RVALID=0 during reset, ARREADY=1 the cycle after RST falls, no stale beats.
REQ-033 SHALL test the macro: write to 0x4000 (MEM_WORDS=4096) → BRESP 2'b10 with AXI_RAM_RANGE_CHECK_EN; address 0x0 modified without it.
